instr_fetch: RTL

Instruction fetch unit. It is the initiator side of the instruction ROM interface: it owns the program counter, drives the ROM byte address, and captures the 32-bit little-endian opcode the ROM returns one clock later. Fetched words are buffered and handed to the decoder over a valid/ready handshake. A jump input redirects the fetch stream and flushes stale work.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_skid_fifo.sv | 63 ++++++
 rtl/instr_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, defaults and types for the instruction fetch slice.
//   PC_W / INSTR_W : byte-address and opcode widths
//   DEF_PC_STEP    : default byte increment per sequential fetch
//   fetch_state_t  : fetch FSM states
//   fetch_entry_t  : one buffered instruction {pc, data}
package fetch_pkg;
    localparam int PC_W        = 8;
    localparam int INSTR_W     = 32;
    localparam int DEF_PC_STEP = 4;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] data;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: first-word-fall-through buffer of fetch entries.
//   clk, rst      : clock, synchronous active-high reset
//   i_push/entry  : write one entry
//   i_pop         : consume the head entry (ignored when empty)
//   i_flush       : drop all entries (wins over push/pop)
//   o_head/o_valid: head entry, zero when empty; valid when non-empty
//   o_count       : current occupancy
// The producer never pushes while full, so there is no overflow guard.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_entry,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !rst) r_mem[r_wr_ptr] <= i_push_entry;
    end

    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit, initiator of the instruction ROM.
//   clk, rst              : clock, synchronous active-high reset
//   rom_address           : byte address presented to the ROM (registered there)
//   rom_opcode            : ROM data for the address sampled one edge earlier
//   jump_valid/target     : redirect pulse and byte target
//   inst_valid/ready      : decoder handshake; inst_data/inst_pc from buffer head
// Optional (macro INSTR_FETCH_PERF_EN): perf_fetched / perf_stall saturating
// 16-bit counters of accepted instructions and backpressured cycles.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 8'h00,
    parameter int              PC_STEP    = DEF_PC_STEP,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    rom_address,
    input  logic [INSTR_W-1:0] rom_opcode,
    input  logic               jump_valid,
    input  logic [PC_W-1:0]    jump_target,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [PC_W-1:0]    inst_pc
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_stall
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_inflight_pc;
    logic             r_inflight_valid;

    logic             w_jump;
    logic             w_pop;
    logic             w_credit;
    logic             w_issue;
    logic             w_push;
    logic [PC_W-1:0]  w_issue_addr;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_occ;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    assign w_jump = jump_valid && !rst;
    assign w_pop  = inst_valid && inst_ready;

    // Buffered + in-flight after this cycle's pop; a slot must remain for
    // the response of anything issued now.
    assign w_occ    = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_inflight_valid) - (CNT_W+1)'(w_pop);
    assign w_credit = (w_occ < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        w_state_nxt  = RUN;
        w_issue      = w_credit;
        w_issue_addr = r_pc;
        w_push       = r_inflight_valid;
        unique case (r_state)
            RUN:      w_state_nxt = RUN;
            // The response arriving here was issued by the jump, so it is kept.
            REDIRECT: w_state_nxt = RUN;
        endcase
        if (w_jump) begin
            // Buffer is flushed this edge, so the target always has room and
            // the pre-jump response on rom_opcode is dropped.
            w_state_nxt  = REDIRECT;
            w_issue      = 1'b1;
            w_issue_addr = jump_target;
            w_push       = 1'b0;
        end
    end

    assign rom_address = w_issue_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= RUN;
            r_pc             <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_inflight_valid <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= w_issue_addr;
                r_pc          <= w_issue_addr + PC_W'(PC_STEP);
            end
        end
    end

    assign w_push_entry = '{pc: r_inflight_pc, data: rom_opcode};

    fetch_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_flush      (w_jump),
        .o_head       (w_head),
        .o_valid      (inst_valid),
        .o_count      (w_count)
    );

    assign inst_data = w_head.data;
    assign inst_pc   = w_head.pc;

`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop && r_perf_fetched != 16'hFFFF)
                r_perf_fetched <= r_perf_fetched + 16'd1;
            if (inst_valid && !inst_ready && r_perf_stall != 16'hFFFF)
                r_perf_stall <= r_perf_stall + 16'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif
endmodule
